// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - left-to-right square-and-multiply sequencer for modular exponentiation
module mod_exp_ctrl #(
    parameter int WIDTH = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   base,
    input  logic [WIDTH-1:0]   exp,
    input  logic [WIDTH-1:0]   modulus,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               div_start,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_q,
    output logic [WIDTH-1:0]   div_m,
    input  logic               div_done,
    input  logic [WIDTH-1:0]   div_r
);
    localparam int IW  = $clog2(WIDTH) + 1;
    localparam int FCW = $clog2(WIDTH + 2) + 1;

    typedef enum logic [3:0] {
        FLUSH, IDLE, RB_ISSUE, RB_WAIT,
        SQ_MUL, SQ_MWAIT, SQ_DIV, SQ_DWAIT,
        ML_MUL, ML_MWAIT, ML_DIV, ML_DWAIT,
        NEXT, FIN
    } state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     e_reg, n_reg, b_reg, acc;
    logic [2*WIDTH-1:0]   prod;
    logic [IW-1:0]        idx;
    logic [FCW-1:0]       flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= FLUSH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FLUSH:    if (flush_cnt == FCW'(WIDTH + 1)) state_nx = IDLE;
            IDLE:     if (start) state_nx = (modulus < WIDTH'(2)) ? FIN : RB_ISSUE;
            RB_ISSUE: state_nx = RB_WAIT;
            RB_WAIT:  if (div_done) state_nx = SQ_MUL;
            SQ_MUL:   state_nx = SQ_MWAIT;
            SQ_MWAIT: if (mul_done) state_nx = SQ_DIV;
            SQ_DIV:   state_nx = SQ_DWAIT;
            SQ_DWAIT: if (div_done) state_nx = e_reg[idx[IW-2:0]] ? ML_MUL : NEXT;
            ML_MUL:   state_nx = ML_MWAIT;
            ML_MWAIT: if (mul_done) state_nx = ML_DIV;
            ML_DIV:   state_nx = ML_DWAIT;
            ML_DWAIT: if (div_done) state_nx = NEXT;
            NEXT:     state_nx = (idx == '0) ? FIN : SQ_MUL;
            FIN:      state_nx = IDLE;
            default:  state_nx = FLUSH;
        endcase
    end

    // b_reg holds the raw base until the reduction result replaces it
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            done      <= 1'b0;
            result    <= '0;
            e_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            prod      <= '0;
            idx       <= '0;
        end else begin
            done      <= (state == FIN);
            flush_cnt <= (state == FLUSH) ? flush_cnt + FCW'(1) : '0;
            case (state)
                IDLE: if (start) begin
                    e_reg <= exp;
                    n_reg <= modulus;
                    b_reg <= base;
                    acc   <= WIDTH'(1);
                    idx   <= IW'(WIDTH - 1);
                    if (modulus < WIDTH'(2)) result <= '0;
                end
                RB_WAIT:            if (div_done) b_reg <= div_r;
                SQ_MWAIT, ML_MWAIT: if (mul_done) prod <= mul_p;
                SQ_DWAIT, ML_DWAIT: if (div_done) acc <= div_r;
                NEXT: begin
                    if (idx == '0) result <= acc;
                    else           idx <= idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

    // operands are decoded from state so they hold steady across the whole wait
    always_comb begin
        busy      = (state != IDLE);
        mul_start = (state == SQ_MUL) || (state == ML_MUL);
        div_start = (state == RB_ISSUE) || (state == SQ_DIV) || (state == ML_DIV);
        mul_a     = '0;
        mul_b     = '0;
        div_a     = '0;
        div_q     = '0;
        div_m     = n_reg;
        case (state)
            RB_ISSUE, RB_WAIT: div_q = b_reg;
            SQ_MUL, SQ_MWAIT: begin
                mul_a = acc;
                mul_b = acc;
            end
            ML_MUL, ML_MWAIT: begin
                mul_a = acc;
                mul_b = b_reg;
            end
            SQ_DIV, SQ_DWAIT, ML_DIV, ML_DWAIT: begin
                div_a = prod[2*WIDTH-1:WIDTH];
                div_q = prod[WIDTH-1:0];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb/tb_mod_exp_ctrl.sv - scoreboard bench for mod_exp_ctrl with behavioural multiplier/divider
module tb_mod_exp_ctrl;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   base = '0, exp = '0, modulus = '0;
    logic           busy, done;
    logic [W-1:0]   result;
    logic           mul_start, mul_done = 1'b0;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p = '0;
    logic           div_start, div_done = 1'b0;
    logic [W-1:0]   div_a, div_q, div_m, div_r = '0;

    mod_exp_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .modulus(modulus),
        .busy(busy), .done(done), .result(result),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_p(mul_p),
        .div_start(div_start), .div_a(div_a), .div_q(div_q), .div_m(div_m),
        .div_done(div_done), .div_r(div_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint res;
        int     mul_end;
        int     div_end;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   mul_cnt = 0, div_cnt = 0, div_done_cnt = 0, done_cnt = 0;

    task automatic check(input string nm, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic longint ref_modexp(longint b, longint e, longint n);
        longint r = 1;
        if (n < 2) return 0;
        b = b % n;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r;
    endfunction

    // divider: fixed W+1 latency, deliberately not reset
    initial begin
        int cnt = 0;
        logic [2*W-1:0] dvd = '0;
        logic [W-1:0]   dvs = '1;
        forever begin
            @(negedge clk);
            div_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    div_done = 1'b1;
                    div_r = (dvs == 0) ? '0 : W'(dvd % {{W{1'b0}}, dvs});
                end
            end
            if (div_start === 1'b1) begin
                cnt = W + 1;
                dvd = {div_a, div_q};
                dvs = div_m;
            end
        end
    end

    // multiplier: random 1..4 cycle latency
    initial begin
        int cnt = 0;
        logic [2*W-1:0] p = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mul_done = 1'b1;
                    mul_p = p;
                end
            end
            if (mul_start === 1'b1) begin
                cnt = int'($urandom_range(1, 4));
                p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mul_start === 1'b1) mul_cnt++;
            if (div_start === 1'b1) div_cnt++;
            if (div_done) div_done_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done: got done=1 expected no done");
                end else begin
                    e = exp_q.pop_front();
                    check("result", longint'(result), e.res);
                    check("mul_count", mul_cnt, e.mul_end);
                    check("div_count", div_cnt, e.div_end);
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check({nm, "_timeout"}, 1, 0);
    endtask

    task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        exp_t x;
        int pc;
        wait_idle("pre_issue");
        pc = $countones(e);
        x.res     = ref_modexp(longint'(b), longint'(e), longint'(n));
        x.mul_end = mul_cnt + ((n < 2) ? 0 : W + pc);
        x.div_end = div_cnt + ((n < 2) ? 0 : 1 + W + pc);
        exp_q.push_back(x);
        base = b;
        exp = e;
        modulus = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        issue(b, e, n);
        wait_idle("run");
    endtask

    task automatic measure_flush(input string nm);
        int k = 0;
        while (busy === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(nm, k, W + 2);
    endtask

    initial begin
        int d0, k, dd0;
        @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_div_start", div_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_div_q", div_q, 0);
        @(negedge clk);
        rst = 1'b0;
        measure_flush("init_flush_len");

        run(4, 13, 497);
        run(65, 17, 3233);
        run(2790, 413, 3233);
        run(10, 1, 7);
        run(3, 0, 7);

        // degenerate modulus: no datapath use, done two cycles after start
        issue(16'hBEEF, 16'h1234, 1);
        check("n1_done_early", done, 0);
        @(negedge clk);
        check("n1_done_lat", done, 1);
        wait_idle("n1");
        run(5, 3, 0);

        for (int i = 0; i < 6; i++)
            run(W'($urandom), W'($urandom), W'($urandom_range(2, (1 << (W - 1)) - 1)));

        // start held while busy must not recapture or restart
        d0 = done_cnt;
        issue(4, 13, 497);
        k = 0;
        while (busy === 1'b1 && k < 3000) begin
            start = 1'b1;
            base = W'($urandom);
            exp = W'($urandom);
            modulus = W'($urandom_range(2, 100));
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("spam_done_count", done_cnt - d0, 1);

        // reset while the divider is in flight during a square step
        issue(4, 13, 497);
        k = 0;
        while (div_cnt < exp_q[0].div_end - 18 && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        dd0 = div_done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        measure_flush("mid_rst_flush_len");
        check("stale_div_done_seen", div_done_cnt - dd0, 1);
        check("no_done_after_abort", done_cnt - d0, 0);
        run(4, 13, 497);

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
